// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a combinational writeback forwarding port.
module mem_wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_CTRL_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WB_CTRL_W-1:0]  control_wb_in,
  input  logic [DATA_W-1:0]     read_data_in,
  input  logic [DATA_W-1:0]     ALU_result_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WB_CTRL_W-1:0]  mem_control_wb,
  output logic [DATA_W-1:0]     read_data,
  output logic [DATA_W-1:0]     mem_ALU_result,
  output logic [REG_ADDR_W-1:0] mem_write_reg,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_value,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, next_state;

  logic [WB_CTRL_W-1:0]  main_ctrl, skid_ctrl;
  logic [DATA_W-1:0]     main_rd, skid_rd;
  logic [DATA_W-1:0]     main_alu, skid_alu;
  logic [REG_ADDR_W-1:0] main_reg, skid_reg;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= next_state;
  end

  // Flush overrides every transition and suppresses all slot loads.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          next_state = EMPTY;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          next_state = TWO;
        end
      end
      TWO: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_ctrl <= '0;
      main_rd   <= '0;
      main_alu  <= '0;
      main_reg  <= '0;
    end else if (load_main_in) begin
      main_ctrl <= control_wb_in;
      main_rd   <= read_data_in;
      main_alu  <= ALU_result_in;
      main_reg  <= write_reg_in;
    end else if (load_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_rd   <= skid_rd;
      main_alu  <= skid_alu;
      main_reg  <= skid_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_ctrl <= '0;
      skid_rd   <= '0;
      skid_alu  <= '0;
      skid_reg  <= '0;
    end else if (load_skid) begin
      skid_ctrl <= control_wb_in;
      skid_rd   <= read_data_in;
      skid_alu  <= ALU_result_in;
      skid_reg  <= write_reg_in;
    end
  end

  // Bubbles must never look like a register write downstream.
  assign mem_control_wb = out_valid ? main_ctrl : '0;
  assign read_data      = main_rd;
  assign mem_ALU_result = main_alu;
  assign mem_write_reg  = main_reg;

  assign fwd_en    = out_valid & main_ctrl[1] & (main_reg != '0);
  assign fwd_reg   = main_reg;
  assign fwd_value = main_ctrl[0] ? main_rd : main_alu;

  always_comb begin
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
